// File: rtl/segment7_pkg.sv
// Shared types, glyph table and control-word bit positions for the segment7 display back-end.
package segment7_pkg;

  typedef logic [3:0] digit_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_BCD_MODE   = 1;
  localparam int CTRL_DP_LSB     = 4;
  localparam int CTRL_BLANK_LSB  = 8;
  localparam int CTRL_BRIGHT_LSB = 16;

  // Active-low glyphs for a common-anode display, bit0 = segment a.
  function automatic logic [6:0] seg_decode(input digit_t d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/segment7_bin2bcd.sv
// Sequential double-dabble: 14-bit binary to four BCD digits in 16 clocks (capture, 14 shifts, commit).
module segment7_bin2bcd
  import segment7_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, COMMIT} state_t;

  state_t      state, state_next;
  logic [13:0] operand;
  logic [29:0] work;
  logic [3:0]  step;

  function automatic logic [29:0] dd_step(input logic [29:0] v);
    logic [29:0] t;
    t = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (t[14 + 4*i +: 4] >= 4'd5) t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = CAPTURE;
      end
      CAPTURE: state_next = SHIFT;
      SHIFT:   if (step == 4'd13) state_next = COMMIT;
      COMMIT: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers only change at commit, so readers never see a partial conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand <= '0;
      work    <= '0;
      step    <= '0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (start) operand <= bin;
        CAPTURE: begin
          work <= {16'd0, operand};
          step <= '0;
        end
        SHIFT: begin
          work <= dd_step(work);
          step <= step + 4'd1;
        end
        COMMIT: begin
          bcd <= work[29:14];
          ovf <= (operand > 14'd9999);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/segment7_scan.sv
// 4-digit multiplexed 7-segment scanner with blanking, decimal points and 16-level PWM.
// Optional binary-to-BCD display mode is compiled in with SEGMENT7_BCD_EN.
module segment7_scan
  import segment7_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic [31:0] disp_value,
  input  logic [31:0] disp_ctrl,
  input  logic [31:0] scan_div,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic [31:0] status,
  output logic        frame_pulse
);

  logic [DIV_WIDTH-1:0] presc;
  logic [3:0]           phase;
  logic [1:0]           digit;
  logic                 tick;
  logic                 enable;
  logic [3:0]           brightness;
  logic [3:0]           dp_bits;
  logic [3:0]           blank_bits;
  logic                 blank_lat;
  logic                 bcd_busy;
  digit_t               hex_digit;
  logic [6:0]           glyph;
  logic                 unused_bits;

  assign enable     = disp_ctrl[CTRL_ENABLE];
  assign brightness = disp_ctrl[CTRL_BRIGHT_LSB +: 4];
  assign dp_bits    = disp_ctrl[CTRL_DP_LSB +: 4];
  assign blank_bits = disp_ctrl[CTRL_BLANK_LSB +: 4];
  assign hex_digit  = disp_value[{digit, 2'b00} +: 4];
  assign tick       = (presc >= scan_div[DIV_WIDTH-1:0]);
  assign status     = {29'd0, bcd_busy, digit};

`ifdef SEGMENT7_BCD_EN
  logic [14:0] bcd_req;
  logic [14:0] bcd_last;
  logic        bcd_start;
  logic        bcd_done;
  logic        bcd_ovf;
  logic [15:0] bcd_val;

  // Any change of operand or mode restarts a conversion once the converter is idle.
  assign bcd_req   = {disp_ctrl[CTRL_BCD_MODE], disp_value[13:0]};
  assign bcd_start = !bcd_busy && (bcd_req != bcd_last);

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) bcd_last <= '0;
    else if (bcd_start)   bcd_last <= bcd_req;
  end

  segment7_bin2bcd u_bin2bcd (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .start (bcd_start),
    .bin   (disp_value[13:0]),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd_val),
    .ovf   (bcd_ovf)
  );

  always_comb begin
    glyph = seg_decode(hex_digit);
    if (disp_ctrl[CTRL_BCD_MODE]) glyph = bcd_ovf ? SEG_DASH : seg_decode(bcd_val[{digit, 2'b00} +: 4]);
  end

  assign unused_bits = ^{disp_value[31:16], disp_ctrl[31:20], disp_ctrl[15:12], disp_ctrl[3:2],
                         scan_div[31:DIV_WIDTH], bcd_done};
`else
  assign bcd_busy = 1'b0;

  always_comb glyph = seg_decode(hex_digit);

  assign unused_bits = ^{disp_value[31:16], disp_ctrl[31:20], disp_ctrl[15:12], disp_ctrl[3:1],
                         scan_div[31:DIV_WIDTH]};
`endif

  // Stage 0: prescaler, phase and digit counters.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      presc <= '0;
      phase <= '0;
      digit <= '0;
    end else if (!enable) begin
      presc <= '0;
      phase <= '0;
      digit <= '0;
    end else if (tick) begin
      presc <= '0;
      phase <= phase + 4'd1;
      if (phase == 4'hF) digit <= digit + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Stage 1: registered display outputs; phase 0 is the dark guard slot where the new glyph loads.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      an_n        <= 4'hF;
      seg_n       <= SEG_BLANK;
      dp_n        <= 1'b1;
      blank_lat   <= 1'b1;
      frame_pulse <= 1'b0;
    end else if (!enable) begin
      an_n        <= 4'hF;
      seg_n       <= SEG_BLANK;
      dp_n        <= 1'b1;
      blank_lat   <= 1'b1;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= tick && (phase == 4'hF) && (digit == 2'd3);
      if (phase == 4'd0) begin
        an_n      <= 4'hF;
        blank_lat <= blank_bits[digit];
        seg_n     <= blank_bits[digit] ? SEG_BLANK : glyph;
        dp_n      <= blank_bits[digit] ? 1'b1 : ~dp_bits[digit];
      end else if ((phase <= brightness) && !blank_lat) begin
        an_n <= ~(4'b0001 << digit);
      end else begin
        an_n <= 4'hF;
      end
    end
  end

endmodule

// File: tb/tb_segment7_scan.sv
// Directed, table-driven bench for segment7_scan; BCD checks are included when SEGMENT7_BCD_EN is defined.
module tb_segment7_scan;

  logic        clk;
  logic        rst_n;
  logic [31:0] value;
  logic [31:0] ctrl;
  logic [31:0] div;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic [31:0] status;
  logic        frame_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  segment7_scan #(.DIV_WIDTH(16)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .disp_value      (value),
    .disp_ctrl       (ctrl),
    .scan_div        (div),
    .seg_n           (seg_n),
    .dp_n            (dp_n),
    .an_n            (an_n),
    .status          (status),
    .frame_pulse     (frame_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic [31:0] ctrl;
    logic [31:0] div;
    int          k;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  dig;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] v, input logic [31:0] c, input logic [31:0] d);
    @(negedge clk);
    rst_n = 1'b0;
    value = v;
    ctrl  = c;
    div   = d;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lows[4];
    int busy_cnt;
    logic [3:0] ph;
    logic [1:0] dg;
    logic [3:0] exp_an;

    // value, ctrl, scan_div, clocks after reset, an_n, seg_n, dp_n, status digit
    vecs[0]  = '{32'h0000_1234, 32'h000F_0001, 32'd0,  1, 4'hF, 7'h19, 1'b1, 2'd0};
    vecs[1]  = '{32'h0000_1234, 32'h000F_0001, 32'd0,  2, 4'hE, 7'h19, 1'b1, 2'd0};
    vecs[2]  = '{32'h0000_1234, 32'h000F_0001, 32'd0, 16, 4'hE, 7'h19, 1'b1, 2'd1};
    vecs[3]  = '{32'h0000_1234, 32'h000F_0001, 32'd0, 17, 4'hF, 7'h30, 1'b1, 2'd1};
    vecs[4]  = '{32'h0000_1234, 32'h000F_0001, 32'd0, 18, 4'hD, 7'h30, 1'b1, 2'd1};
    vecs[5]  = '{32'h0000_1234, 32'h000F_0001, 32'd0, 34, 4'hB, 7'h24, 1'b1, 2'd2};
    vecs[6]  = '{32'h0000_1234, 32'h000F_0001, 32'd0, 50, 4'h7, 7'h79, 1'b1, 2'd3};
    vecs[7]  = '{32'h0000_1234, 32'h000F_0001, 32'd0, 66, 4'hE, 7'h19, 1'b1, 2'd0};
    vecs[8]  = '{32'h0000_F80A, 32'h000F_0001, 32'd0,  2, 4'hE, 7'h08, 1'b1, 2'd0};
    vecs[9]  = '{32'h0000_F80A, 32'h000F_0001, 32'd0, 18, 4'hD, 7'h40, 1'b1, 2'd1};
    vecs[10] = '{32'h0000_F80A, 32'h000F_0001, 32'd0, 34, 4'hB, 7'h00, 1'b1, 2'd2};
    vecs[11] = '{32'h0000_F80A, 32'h000F_0001, 32'd0, 50, 4'h7, 7'h0E, 1'b1, 2'd3};
    vecs[12] = '{32'h0000_1234, 32'h0003_0001, 32'd0,  4, 4'hE, 7'h19, 1'b1, 2'd0};
    vecs[13] = '{32'h0000_1234, 32'h0003_0001, 32'd0,  5, 4'hF, 7'h19, 1'b1, 2'd0};
    vecs[14] = '{32'h0000_1234, 32'h000F_0521, 32'd0,  2, 4'hF, 7'h7F, 1'b1, 2'd0};
    vecs[15] = '{32'h0000_1234, 32'h000F_0521, 32'd0, 18, 4'hD, 7'h30, 1'b0, 2'd1};
    vecs[16] = '{32'h0000_1234, 32'h000F_0521, 32'd0, 34, 4'hF, 7'h7F, 1'b1, 2'd2};
    vecs[17] = '{32'h0000_1234, 32'h000F_0521, 32'd0, 50, 4'h7, 7'h79, 1'b1, 2'd3};
    vecs[18] = '{32'h0000_1234, 32'h000F_0001, 32'd2,  4, 4'hE, 7'h19, 1'b1, 2'd0};
    vecs[19] = '{32'h0000_1234, 32'h000F_0000, 32'd0,  5, 4'hF, 7'h7F, 1'b1, 2'd0};

    rst_n = 1'b0;
    value = '0;
    ctrl  = '0;
    div   = '0;
    repeat (2) @(negedge clk);
    chk("reset_an", {28'd0, an_n}, 32'hF);
    chk("reset_seg", {25'd0, seg_n}, 32'h7F);
    chk("reset_dp", {31'd0, dp_n}, 32'h1);
    chk("reset_status", status, 32'h0);
    chk("reset_frame", {31'd0, frame_pulse}, 32'h0);

    foreach (vecs[i]) begin
      do_reset(vecs[i].value, vecs[i].ctrl, vecs[i].div);
      run(vecs[i].k);
      chk($sformatf("vec%0d_an", i), {28'd0, an_n}, {28'd0, vecs[i].an});
      chk($sformatf("vec%0d_seg", i), {25'd0, seg_n}, {25'd0, vecs[i].seg});
      chk($sformatf("vec%0d_dp", i), {31'd0, dp_n}, {31'd0, vecs[i].dp});
      chk($sformatf("vec%0d_digit", i), {30'd0, status[1:0]}, {30'd0, vecs[i].dig});
    end

    // Full-brightness scan: guard slot every 16 clocks, frame pulse every 64.
    do_reset(32'h0000_1234, 32'h000F_0001, 32'd0);
    for (int k = 1; k <= 200; k++) begin
      run(1);
      ph     = 4'((k - 1) % 16);
      dg     = 2'(((k - 1) / 16) % 4);
      exp_an = (ph == 4'd0) ? 4'hF : ~(4'b0001 << dg);
      chk($sformatf("scan_an_k%0d", k), {28'd0, an_n}, {28'd0, exp_an});
      chk($sformatf("frame_k%0d", k), {31'd0, frame_pulse}, {31'd0, (k % 64) == 0});
    end

    // Brightness 3: each anode low for exactly 3 clocks per frame.
    do_reset(32'h0000_1234, 32'h0003_0001, 32'd0);
    for (int d = 0; d < 4; d++) lows[d] = 0;
    for (int k = 1; k <= 64; k++) begin
      run(1);
      for (int d = 0; d < 4; d++) if (!an_n[d]) lows[d]++;
    end
    for (int d = 0; d < 4; d++) chk($sformatf("bright3_low_an%0d", d), lows[d], 32'd3);

    // Disable mid-slot with scan_div=9, then re-enable.
    do_reset(32'h0000_1234, 32'h000F_0001, 32'd9);
    run(25);
    chk("div9_active", {28'd0, an_n}, 32'hE);
    ctrl = 32'h000F_0000;
    run(1);
    chk("disable_an", {28'd0, an_n}, 32'hF);
    chk("disable_seg", {25'd0, seg_n}, 32'h7F);
    run(3);
    ctrl = 32'h000F_0001;
    for (int k = 1; k <= 20; k++) begin
      run(1);
      chk($sformatf("reenable_an_k%0d", k), {28'd0, an_n}, (k <= 10) ? 32'hF : 32'hE);
    end
    chk("reenable_seg", {25'd0, seg_n}, 32'h19);

    // Asynchronous reset mid-frame.
    do_reset(32'h0000_FFFF, 32'h000F_0001, 32'd0);
    run(20);
    chk("prereset_an", {28'd0, an_n}, 32'hD);
    chk("prereset_seg", {25'd0, seg_n}, 32'h0E);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", {28'd0, an_n}, 32'hF);
    chk("async_seg", {25'd0, seg_n}, 32'h7F);
    chk("async_dp", {31'd0, dp_n}, 32'h1);
    chk("async_status", status, 32'h0);
    chk("async_frame", {31'd0, frame_pulse}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2);
    chk("resume_an", {28'd0, an_n}, 32'hE);

`ifdef SEGMENT7_BCD_EN
    do_reset(32'd1234, 32'h000F_0003, 32'd0);
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      run(1);
      if (status[2]) busy_cnt++;
      if (k == 1)  chk("bcd_busy_first", {31'd0, status[2]}, 32'h1);
      if (k == 17) chk("bcd_busy_done", {31'd0, status[2]}, 32'h0);
    end
    chk("bcd_busy_len", busy_cnt, 32'd16);
    run(26);
    chk("bcd_digit0", {25'd0, seg_n}, 32'h19);
    run(16);
    chk("bcd_digit1", {25'd0, seg_n}, 32'h30);
    run(16);
    chk("bcd_digit2", {25'd0, seg_n}, 32'h24);
    run(16);
    chk("bcd_digit3", {25'd0, seg_n}, 32'h79);

    do_reset(32'd10000, 32'h000F_0003, 32'd0);
    run(66);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("dash_digit%0d_seg", d), {25'd0, seg_n}, 32'h3F);
      chk($sformatf("dash_digit%0d_an", d), {28'd0, an_n}, {28'd0, ~(4'b0001 << d)});
      run(16);
    end
`else
    busy_cnt = 0;
    do_reset(32'h0000_1234, 32'h000F_0003, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      run(1);
      if (status[2]) busy_cnt++;
    end
    chk("nobcd_busy", busy_cnt, 32'd0);
    run(13);
    chk("nobcd_hex_digit2", {25'd0, seg_n}, 32'h24);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
